// File: rtl/fir_sample_source.sv
// ---------------------------------------------------------------------------
// fir_sample_source : programmable sample store played out one per clock,
// framed by zero lead-in and zero tail. Optional feature macro: SRC_LOOP_EN.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fir_sample_source #(
  parameter int SAMPLE_W   = 3,
  parameter int DEPTH      = 16,
  parameter int LEAD_ZEROS = 8,
  parameter int TAIL_ZEROS = 5
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_wr_en,
  input  logic [$clog2(DEPTH)-1:0]  i_wr_addr,
  input  logic [SAMPLE_W-1:0]       i_wr_data,
  input  logic [$clog2(DEPTH):0]    i_len,
  input  logic                      i_start,
  input  logic                      i_hold,
`ifdef SRC_LOOP_EN
  input  logic                      i_loop,
`endif
  output logic [SAMPLE_W-1:0]       o_signal,
  output logic                      o_valid,
  output logic                      o_busy,
  output logic                      o_done,
  output logic [$clog2(DEPTH)-1:0]  o_index
);

  localparam int ADDR_W  = $clog2(DEPTH);
  localparam int CNT_MAX = (LEAD_ZEROS > TAIL_ZEROS) ? LEAD_ZEROS : TAIL_ZEROS;
  localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0]  c_lead_last = CNT_W'((LEAD_ZEROS > 0) ? LEAD_ZEROS - 1 : 0);
  localparam logic [CNT_W-1:0]  c_tail_last = CNT_W'((TAIL_ZEROS > 0) ? TAIL_ZEROS - 1 : 0);
  localparam logic [ADDR_W:0]   c_depth     = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] c_max_idx   = ADDR_W'(DEPTH - 1);

  // S_ARM is the one-cycle prefetch slot between start acceptance and the first output
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ARM  = 3'd1,
    S_LEAD = 3'd2,
    S_PLAY = 3'd3,
    S_TAIL = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t                r_state, w_state_nx;
  logic [CNT_W-1:0]      r_cnt, w_cnt_nx;
  logic [ADDR_W-1:0]     r_idx, w_idx_nx;
  logic [ADDR_W-1:0]     r_last, w_last_nx;
  logic [SAMPLE_W-1:0]   r_sig, w_sig_nx;
  logic                  r_valid, w_valid_nx;
  logic                  r_busy, w_busy_nx;
  logic                  r_done, w_done_nx;
  logic [SAMPLE_W-1:0]   r_mem [DEPTH];
  logic                  w_loop;

`ifdef SRC_LOOP_EN
  assign w_loop = i_loop;
`else
  assign w_loop = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst && i_wr_en && (r_state == S_IDLE)) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_last  <= '0;
      r_sig   <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_idx   <= w_idx_nx;
      r_last  <= w_last_nx;
      r_sig   <= w_sig_nx;
      r_valid <= w_valid_nx;
      r_busy  <= w_busy_nx;
      r_done  <= w_done_nx;
    end
  end

  // Registers hold the outputs of the current cycle; this block computes the next ones
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_idx_nx   = r_idx;
    w_last_nx  = r_last;
    w_sig_nx   = r_sig;
    w_valid_nx = 1'b0;
    w_busy_nx  = r_busy;
    w_done_nx  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_sig_nx  = '0;
        w_idx_nx  = '0;
        w_cnt_nx  = '0;
        w_busy_nx = 1'b0;
        if (i_start && (i_len != '0)) begin
          w_last_nx  = (i_len > c_depth) ? c_max_idx : ADDR_W'(i_len - 1'b1);
          w_state_nx = S_ARM;
        end
      end
      S_ARM: begin
        w_valid_nx = 1'b1;
        w_busy_nx  = 1'b1;
        if (LEAD_ZEROS > 0) begin
          w_state_nx = S_LEAD;
        end else begin
          w_state_nx = S_PLAY;
          w_sig_nx   = r_mem[0];
        end
      end
      S_LEAD: begin
        if (!i_hold) begin
          w_valid_nx = 1'b1;
          if (r_cnt == c_lead_last) begin
            w_state_nx = S_PLAY;
            w_cnt_nx   = '0;
            w_idx_nx   = '0;
            w_sig_nx   = r_mem[0];
          end else begin
            w_cnt_nx = r_cnt + 1'b1;
          end
        end
      end
      S_PLAY: begin
        if (!i_hold) begin
          w_valid_nx = 1'b1;
          if (r_idx != r_last) begin
            w_idx_nx = r_idx + 1'b1;
            w_sig_nx = r_mem[r_idx + 1'b1];
          end else if (w_loop) begin
            w_idx_nx = '0;
            w_sig_nx = r_mem[0];
          end else begin
            w_idx_nx = '0;
            w_sig_nx = '0;
            if (TAIL_ZEROS > 0) begin
              w_state_nx = S_TAIL;
            end else begin
              w_state_nx = S_DONE;
              w_valid_nx = 1'b0;
              w_busy_nx  = 1'b0;
              w_done_nx  = 1'b1;
            end
          end
        end
      end
      S_TAIL: begin
        if (!i_hold) begin
          if (r_cnt == c_tail_last) begin
            w_state_nx = S_DONE;
            w_cnt_nx   = '0;
            w_busy_nx  = 1'b0;
            w_done_nx  = 1'b1;
          end else begin
            w_valid_nx = 1'b1;
            w_cnt_nx   = r_cnt + 1'b1;
          end
        end
      end
      S_DONE: begin
        w_state_nx = S_IDLE;
        w_sig_nx   = '0;
        w_busy_nx  = 1'b0;
      end
      default: begin
        w_state_nx = S_IDLE;
        w_sig_nx   = '0;
        w_idx_nx   = '0;
        w_cnt_nx   = '0;
        w_busy_nx  = 1'b0;
      end
    endcase
  end

  assign o_signal = r_sig;
  assign o_valid  = r_valid;
  assign o_busy   = r_busy;
  assign o_done   = r_done;
  assign o_index  = r_idx;

endmodule

`default_nettype wire

// File: tb/tb_fir_sample_source.sv
// ---------------------------------------------------------------------------
// tb_fir_sample_source : directed self-checking bench for fir_sample_source.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_fir_sample_source;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [2:0] wr_data;
  logic [4:0] len;
  logic       start;
  logic       hold;
  logic       loop_en;
  logic [2:0] sig;
  logic       valid, busy, done;
  logic [3:0] idx;

  int total = 0;
  int bad   = 0;
  logic [2:0] exp_mem [16];

  always #5 clk = ~clk;

  fir_sample_source dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_wr_en   (wr_en),
    .i_wr_addr (wr_addr),
    .i_wr_data (wr_data),
    .i_len     (len),
    .i_start   (start),
    .i_hold    (hold),
`ifdef SRC_LOOP_EN
    .i_loop    (loop_en),
`endif
    .o_signal  (sig),
    .o_valid   (valid),
    .o_busy    (busy),
    .o_done    (done),
    .o_index   (idx)
  );

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic chk_out(input string tag, input logic [2:0] e_sig, input logic e_valid,
                         input logic e_busy, input logic e_done, input logic [3:0] e_idx);
    chk({tag, ".sig"},   32'(sig),   32'(e_sig));
    chk({tag, ".valid"}, 32'(valid), 32'(e_valid));
    chk({tag, ".busy"},  32'(busy),  32'(e_busy));
    chk({tag, ".done"},  32'(done),  32'(e_done));
    chk({tag, ".index"}, 32'(idx),   32'(e_idx));
  endtask

  task automatic wr(input int a, input logic [2:0] d);
    wr_en = 1'b1; wr_addr = 4'(a); wr_data = d;
    exp_mem[a] = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic noise(input bit on);
    wr_en   = on;
    start   = on;
    wr_addr = 4'($urandom);
    wr_data = 3'($urandom);
  endtask

  // One whole frame from the start edge E0 through the return to IDLE.
  task automatic frame(input int len_in, input int n, input int hold_at, input int hold_n,
                       input int passes, input bit nz);
    len = 5'(len_in); start = 1'b1;
    tick();
    start = 1'b0;
    chk_out("e0", 3'd0, 1'b0, 1'b0, 1'b0, 4'd0);
    for (int k = 0; k < 8; k++) begin
      noise(nz);
      tick();
      chk_out("lead", 3'd0, 1'b1, 1'b1, 1'b0, 4'd0);
    end
    for (int p = 0; p < passes; p++) begin
      for (int i = 0; i < n; i++) begin
        noise(nz);
        tick();
        chk_out("play", exp_mem[i], 1'b1, 1'b1, 1'b0, 4'(i));
        if (i == hold_at) begin
          hold = 1'b1;
          for (int h = 0; h < hold_n; h++) begin
            noise(nz);
            tick();
            chk_out("hold", exp_mem[i], 1'b0, 1'b1, 1'b0, 4'(i));
          end
          hold = 1'b0;
        end
        if (i == n - 1) loop_en = (p < passes - 1);
      end
    end
    loop_en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      noise(nz);
      tick();
      chk_out("tail", 3'd0, 1'b1, 1'b1, 1'b0, 4'd0);
    end
    tick();
    noise(1'b0);
    chk_out("done", 3'd0, 1'b0, 1'b0, 1'b1, 4'd0);
    tick();
    chk_out("idle", 3'd0, 1'b0, 1'b0, 1'b0, 4'd0);
  endtask

  initial begin
    logic [2:0] vec [12] = '{3'd6, 3'd4, 3'd1, 3'd5, 3'd2, 3'd5, 3'd1, 3'd0, 3'd7, 3'd2, 3'd2, 3'd0};
    logic [2:0] vec16 [16] = '{3'd3, 3'd1, 3'd4, 3'd1, 3'd5, 3'd7, 3'd2, 3'd6,
                               3'd5, 3'd3, 3'd5, 3'd0, 3'd7, 3'd1, 3'd2, 3'd4};
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; len = '0;
    start = 1'b0; hold = 1'b0; loop_en = 1'b0;
    tick(); tick();
    chk_out("reset", 3'd0, 1'b0, 1'b0, 1'b0, 4'd0);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick(); tick();
    chk_out("rst_idle", 3'd0, 1'b0, 1'b0, 1'b0, 4'd0);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) wr(i, vec[i]);
    frame(12, 12, -1, 0, 1, 1'b0);
    frame(12, 12, 4, 3, 1, 1'b0);

    // writes and start strobes during a frame must be ignored; replay reads store back
    frame(12, 12, -1, 0, 1, 1'b1);
    frame(12, 12, -1, 0, 1, 1'b0);

    len = 5'd0; start = 1'b1;
    tick();
    chk_out("len0_a", 3'd0, 1'b0, 1'b0, 1'b0, 4'd0);
    start = 1'b0;
    tick();
    chk_out("len0_b", 3'd0, 1'b0, 1'b0, 1'b0, 4'd0);

    for (int i = 0; i < 16; i++) wr(i, vec16[i]);
    frame(20, 16, -1, 0, 1, 1'b0);

    for (int i = 0; i < 12; i++) wr(i, vec[i]);
    len = 5'd12; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 12; k++) tick();
    chk_out("pre_rst", exp_mem[3], 1'b1, 1'b1, 1'b0, 4'd3);
    rst = 1'b1;
    tick();
    chk_out("mid_rst", 3'd0, 1'b0, 1'b0, 1'b0, 4'd0);
    rst = 1'b0;
    frame(12, 12, -1, 0, 1, 1'b0);

`ifdef SRC_LOOP_EN
    frame(12, 12, -1, 0, 3, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
